poly_pack_stream: RTL and testbench

- Streaming, parametrised successor to the fixed 13-bit t0 packer.
- Accepts one signed polynomial coefficient per handshake. Maps it as t = OFFSET - coeff (NEGATE=1) or t = coeff + OFFSET (NEGATE=0), keeps t[BITS-1:0], and emits the LSB-first packed bitstream one byte per handshake.
- One instance covers the t0 (13b), t1 (10b), eta (3b/4b) and z (18b/20b) encodings. It sits between the polynomial RAM reader and the signature/key byte buffer.

---
 rtl/poly_pack_stream.sv | 108 ++++++++++
 tb/tb_poly_pack_stream.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_pack_stream.sv
// Streaming polynomial coefficient packer: maps each signed coefficient to an
// unsigned BITS-wide value and emits the LSB-first packed bitstream a byte at a time.
module poly_pack_stream #(
  parameter int N      = 256,
  parameter int COEF_W = 32,
  parameter int BITS   = 13,
  parameter int OFFSET = 4096,
  parameter bit NEGATE = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COEF_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_last,
  output logic              range_err,
  output logic              busy
);

  localparam int ACC_W  = BITS + 7;
  localparam int FILL_W = $clog2(BITS + 17);  // wide enough to compare against 16
  localparam int TW     = COEF_W + 2;
  localparam int NB     = N * BITS / 8;
  localparam int CCNT_W = $clog2(N > 1 ? N : 2);
  localparam int BCNT_W = $clog2(NB > 1 ? NB : 2);

  localparam logic signed [TW-1:0] OFFSET_S = TW'(OFFSET);

  logic [ACC_W-1:0]  acc_q, acc_d, acc_base, t_ext;
  logic [FILL_W-1:0] fill_q, fill_d, fill_base;
  logic [CCNT_W-1:0] ccnt_q, ccnt_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              range_err_q, range_err_d;

  logic signed [TW-1:0] coef_s, t_s;
  logic                 t_oor;
  logic                 fire_in, fire_out;

  // Two guard bits keep OFFSET +/- coeff exact for any coefficient.
  assign coef_s = {{2{in_data[COEF_W-1]}}, in_data};
  assign t_s    = NEGATE ? (OFFSET_S - coef_s) : (coef_s + OFFSET_S);
  assign t_oor  = t_s[TW-1] | (|t_s[TW-2:BITS]);
  assign t_ext  = ACC_W'(t_s[BITS-1:0]);

  assign out_valid = (fill_q >= FILL_W'(8));
  assign out_data  = acc_q[7:0];
  assign out_last  = out_valid && (bcnt_q == BCNT_W'(NB - 1));
  assign range_err = range_err_q;
  assign busy      = (|ccnt_q) || (|fill_q);

  // Accepting alongside a byte drain is allowed only while the post-drain fill stays below 8.
  assign in_ready = (fill_q < FILL_W'(8)) || ((fill_q < FILL_W'(16)) && out_ready);

  assign fire_out = out_valid && out_ready;
  assign fire_in  = in_valid && in_ready;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    acc_base    = fire_out ? (acc_q >> 8) : acc_q;
    fill_base   = fire_out ? (fill_q - FILL_W'(8)) : fill_q;
    acc_d       = acc_base;
    fill_d      = fill_base;
    ccnt_d      = ccnt_q;
    bcnt_d      = bcnt_q;
    range_err_d = range_err_q;

    if (fire_in) begin
      acc_d       = acc_base | (t_ext << fill_base);
      fill_d      = fill_base + FILL_W'(BITS);
      ccnt_d      = (ccnt_q == CCNT_W'(N - 1)) ? '0 : ccnt_q + CCNT_W'(1);
      range_err_d = (ccnt_q == '0) ? t_oor : (range_err_q | t_oor);
    end

    if (fire_out) begin
      bcnt_d = (bcnt_q == BCNT_W'(NB - 1)) ? '0 : bcnt_q + BCNT_W'(1);
    end

    if (clr) begin
      acc_d       = '0;
      fill_d      = '0;
      ccnt_d      = '0;
      bcnt_d      = '0;
      range_err_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      fill_q      <= '0;
      ccnt_q      <= '0;
      bcnt_q      <= '0;
      range_err_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      fill_q      <= fill_d;
      ccnt_q      <= ccnt_d;
      bcnt_q      <= bcnt_d;
      range_err_q <= range_err_d;
    end
  end

endmodule

// File: tb/tb_poly_pack_stream.sv
// Directed bench for poly_pack_stream: 13-bit t0 and 3-bit eta configurations,
// backpressure, back-to-back frames, clr and mid-frame reset.
module tb_poly_pack_stream;

  typedef logic [7:0] byteq_t[$];

  logic clk, rst_n, clr;
  logic in_valid13, in_ready13, out_valid13, out_ready13, out_last13, range_err13, busy13;
  logic [31:0] in_data13;
  logic [7:0]  out_data13;
  logic in_valid3, in_ready3, out_valid3, out_ready3, out_last3, range_err3, busy3;
  logic [31:0] in_data3;
  logic [7:0]  out_data3;

  int checks = 0;
  int failures = 0;

  byteq_t got_q;
  int     last_q[$];
  int     ready_drops;
  int     last_with_in;
  logic   re_before, re_after_first;

  localparam int BIG = 1000000;

  poly_pack_stream #(.N(256), .COEF_W(32), .BITS(13), .OFFSET(4096), .NEGATE(1'b1)) dut13 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid13), .in_ready(in_ready13), .in_data(in_data13),
    .out_valid(out_valid13), .out_ready(out_ready13), .out_data(out_data13),
    .out_last(out_last13), .range_err(range_err13), .busy(busy13)
  );

  poly_pack_stream #(.N(256), .COEF_W(32), .BITS(3), .OFFSET(2), .NEGATE(1'b1)) dut3 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .out_last(out_last3), .range_err(range_err3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference packer built on an explicit bit queue.
  function automatic byteq_t model_pack(input int coefs[$], input int bits,
                                        input longint offset, input bit negate);
    byteq_t     res;
    bit         bitq[$];
    longint     t;
    logic [7:0] b;
    foreach (coefs[k]) begin
      t = negate ? offset - longint'(coefs[k]) : longint'(coefs[k]) + offset;
      for (int i = 0; i < bits; i++) bitq.push_back(t[i]);
      while (bitq.size() >= 8) begin
        for (int i = 0; i < 8; i++) b[i] = bitq.pop_front();
        res.push_back(b);
      end
    end
    return res;
  endfunction

  // Cycle loop entered just after a falling edge; samples 1 time unit later.
  task automatic run(input int which, input int coefs[$], input int exp_bytes,
                     input int stop_coefs, input int stall_at, input int stall_len,
                     input logic [7:0] stall_exp);
    int   idx = 0;
    int   cyc = 0;
    int   stall_cnt = 0;
    bit   rec = 0;
    logic ivalid, oready, rdy, ov, ol, re, fi, fo;
    logic [7:0] od;
    got_q.delete();
    last_q.delete();
    ready_drops  = 0;
    last_with_in = -1;
    while (got_q.size() < exp_bytes && idx < stop_coefs) begin
      if (cyc >= 5000) begin
        check("run_timeout_bytes", got_q.size(), exp_bytes);
        break;
      end
      oready = !(got_q.size() == stall_at && stall_cnt < stall_len);
      ivalid = (idx < coefs.size());
      if (which == 0) begin
        out_ready13 = oready; in_valid13 = ivalid;
        in_data13 = ivalid ? coefs[idx] : 32'd0;
      end else begin
        out_ready3 = oready; in_valid3 = ivalid;
        in_data3 = ivalid ? coefs[idx] : 32'd0;
      end
      #1;
      rdy = which == 0 ? in_ready13  : in_ready3;
      ov  = which == 0 ? out_valid13 : out_valid3;
      ol  = which == 0 ? out_last13  : out_last3;
      od  = which == 0 ? out_data13  : out_data3;
      re  = which == 0 ? range_err13 : range_err3;
      if (cyc == 0) re_before = re;
      if (idx == 1 && !rec) begin
        re_after_first = re;
        rec = 1;
      end
      if (!oready) begin
        stall_cnt++;
        check("stall_out_valid", ov, 1);
        check("stall_out_data", od, stall_exp);
        check("stall_in_ready", rdy, 0);
      end
      if (ivalid && oready && !rdy) ready_drops++;
      fi = ivalid && rdy;
      fo = ov && oready;
      if (fo) begin
        got_q.push_back(od);
        if (ol) last_q.push_back(got_q.size() - 1);
        if (ol && fi) last_with_in = idx;
      end
      if (fi) idx++;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    in_valid13 = 1'b0; in_valid3 = 1'b0;
    out_ready13 = 1'b1; out_ready3 = 1'b1;
  endtask

  task automatic compare(input string tag, input byteq_t exp);
    check({tag, "_nbytes"}, got_q.size(), exp.size());
    foreach (exp[i]) begin
      if (i < got_q.size()) check($sformatf("%s_b%0d", tag, i), got_q[i], exp[i]);
    end
  endtask

  task automatic check_last(input string tag, input int pos);
    check({tag, "_last_cnt"}, last_q.size(), 1);
    if (last_q.size() > 0) check({tag, "_last_pos"}, last_q[0], pos);
  endtask

  initial begin
    int         zeros[$], alt[$], eta[$], b2b[$], f2[$];
    byteq_t     exp1, exp2, exp3, exp5;
    logic [7:0] pat13[13] = '{8'h00, 8'h10, 8'h00, 8'h02, 8'h40, 8'h00, 8'h08,
                              8'h00, 8'h01, 8'h20, 8'h00, 8'h04, 8'h80};
    logic [7:0] pat3[3]   = '{8'h88, 8'h46, 8'h44};
    int         eta_pat[8] = '{2, 1, 0, -1, -2, 2, 1, 0};

    rst_n = 1'b0; clr = 1'b0;
    in_valid13 = 1'b0; in_data13 = '0; out_ready13 = 1'b1;
    in_valid3  = 1'b0; in_data3  = '0; out_ready3  = 1'b1;

    for (int k = 0; k < 256; k++) zeros.push_back(0);
    for (int k = 0; k < 416; k++) exp1.push_back(pat13[k % 13]);
    for (int k = 0; k < 96; k++)  exp3.push_back(pat3[k % 3]);
    for (int k = 0; k < 256; k++) alt.push_back((k % 2 == 0) ? 4096 : -4095);
    alt[4] = 4097;
    exp2 = model_pack(alt, 13, 4096, 1'b1);
    for (int k = 0; k < 256; k++) eta.push_back(eta_pat[k % 8]);
    for (int k = 0; k < 256; k++) f2.push_back(4096 - ((k * 37 + 5) % 8192));
    b2b  = {zeros, f2};
    exp5 = {exp1, model_pack(f2, 13, 4096, 1'b1)};

    // Reset state
    #12;
    check("rst_out_valid", out_valid13, 0);
    check("rst_out_data", out_data13, 0);
    check("rst_out_last", out_last13, 0);
    check("rst_busy", busy13, 0);
    check("rst_range_err", range_err13, 0);
    check("rst_out_valid3", out_valid3, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready13, 1);

    // Scenario 1: all-zero coefficients
    run(0, zeros, 416, BIG, -1, 0, 8'h00);
    compare("s1", exp1);
    check_last("s1", 415);
    check("s1_range_err", range_err13, 0);
    check("s1_busy_end", busy13, 0);

    // Scenario 2: alternating extremes with one out-of-range slot
    run(0, alt, 416, BIG, -1, 0, 8'h00);
    compare("s2", exp2);
    check("s2_first_bytes", {got_q[0], got_q[1], got_q[2], got_q[3]}, 32'h00E0FF03);
    check("s2_range_err", range_err13, 1);
    check("s2_re_after_first", re_after_first, 0);
    run(0, zeros, 416, BIG, -1, 0, 8'h00);
    check("s2_re_sticky", re_before, 1);
    check("s2_re_cleared", re_after_first, 0);
    compare("s2b", exp1);

    // Scenario 3: 3-bit eta encoding
    run(1, eta, 96, BIG, -1, 0, 8'h00);
    compare("s3", exp3);
    check_last("s3", 95);
    check("s3_ready_drops", ready_drops, 0);
    check("s3_range_err", range_err3, 0);

    // Scenario 4: ten-cycle stall at byte 5
    run(0, zeros, 416, BIG, 5, 10, 8'h00);
    compare("s4", exp1);
    check_last("s4", 415);

    // Scenario 5: back-to-back frames
    run(0, b2b, 832, BIG, -1, 0, 8'h00);
    compare("s5", exp5);
    check("s5_last_cnt", last_q.size(), 2);
    if (last_q.size() == 2) begin
      check("s5_last0", last_q[0], 415);
      check("s5_last1", last_q[1], 831);
    end
    check("s5_first_in_at_last", last_with_in, 256);
    check("s5_busy_end", busy13, 0);

    // Scenario 6a: clr after 100 coefficients
    run(0, zeros, BIG, 100, -1, 0, 8'h00);
    check("s6_busy_pre_clr", busy13, 1);
    clr = 1'b1; in_valid13 = 1'b1; in_data13 = '0; out_ready13 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    clr = 1'b0; in_valid13 = 1'b0;
    check("s6_clr_out_valid", out_valid13, 0);
    check("s6_clr_busy", busy13, 0);
    check("s6_clr_in_ready", in_ready13, 1);
    run(0, zeros, 416, BIG, -1, 0, 8'h00);
    compare("s6a", exp1);
    check_last("s6a", 415);

    // Scenario 6b: asynchronous reset mid-frame
    run(0, zeros, BIG, 100, -1, 0, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_rst_out_valid", out_valid13, 0);
    check("s6_rst_busy", busy13, 0);
    check("s6_rst_out_data", out_data13, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(0, zeros, 416, BIG, -1, 0, 8'h00);
    compare("s6b", exp1);
    check_last("s6b", 415);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
